// File: rtl/video_timing_gen.sv
// Video timing generator: divides clk_sys into a pixel enable, scans hcount/vcount
// over a full frame and decodes sync/blank plus a rate-decimated pixel enable.
module video_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 15
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [1:0]  res_sel,
    output logic        ce_pix,
    output logic        ce_pix_actual,
    output logic        HSync,
    output logic        VSync,
    output logic        HBlank,
    output logic        VBlank,
    output logic        line_start,
    output logic [11:0] hcount,
    output logic [10:0] vcount,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_BLANK_BEG  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_BLANK_BEG  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [11:0]      hcount_q, hcount_d;
    logic [10:0]      vcount_q, vcount_d;
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       rate_q, rate_d;
    logic             ce_pix_q, ce_pix_d;
    logic             ce_act_q, ce_act_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblank_q, hblank_d;
    logic             vblank_q, vblank_d;
    logic             frame_start_q, frame_start_d;

    logic             tick;
    logic             frame_wrap;
    logic [1:0]       phase_mask;

    // Counters step on the same edge that raises ce_pix, so every registered
    // output is decoded from the next-state counts and lines up with them.
    always_comb begin
        tick       = (div_cnt_q == DIV_LAST);
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        phase_d    = phase_q;
        rate_d     = rate_q;
        frame_wrap = tick && (hcount_q >= H_LAST) && (vcount_q >= V_LAST);

        if (tick) begin
            if (hcount_q >= H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q >= V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
            phase_d = (hcount_d == '0) ? 2'd0 : phase_q + 2'd1;
        end

        if (frame_wrap) begin
            rate_d = res_sel;
        end

        case (rate_d)
            2'd0:    phase_mask = 2'b00;
            2'd1:    phase_mask = 2'b01;
            default: phase_mask = 2'b11;
        endcase

        ce_pix_d      = tick;
        ce_act_d      = tick && ((phase_d & phase_mask) == 2'b00);
        hblank_d      = (hcount_d >= H_BLANK_BEG);
        hsync_d       = (hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END);
        vblank_d      = (vcount_d >= V_BLANK_BEG);
        vsync_d       = (vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END);
        frame_start_d = frame_wrap;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q     <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            phase_q       <= '0;
            rate_q        <= '0;
            ce_pix_q      <= 1'b0;
            ce_act_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            phase_q       <= phase_d;
            rate_q        <= rate_d;
            ce_pix_q      <= ce_pix_d;
            ce_act_q      <= ce_act_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ce_pix        = ce_pix_q;
    assign ce_pix_actual = ce_act_q;
    assign HSync         = hsync_q;
    assign VSync         = vsync_q;
    assign HBlank        = hblank_q;
    assign VBlank        = vblank_q;
    assign line_start    = hblank_q;
    assign hcount        = hcount_q;
    assign vcount        = vcount_q;
    assign frame_start   = frame_start_q;

endmodule
